// File: rtl/lp_filter_iir_pkg.sv
// lp_filter_pkg: shared constants, types and helpers for the cascaded IIR
// low-pass filter (lp_filter_iir) and its per-section stage (lp_iir_stage).
//   DATA_W_DEF / FRAC_W_DEF / SHIFT_W_DEF / MAX_SHIFT_DEF : default geometry
//   ACC_W   : stage accumulator width (integer sample bits + guard bits)
//   DIFF_W  : signed difference width used inside each stage update
//   acc_t   : accumulator type for the default geometry
//   clamp_shift() : limits a requested smoothing shift to the supported max
package lp_filter_pkg;

  localparam int DATA_W_DEF    = 12;
  localparam int FRAC_W_DEF    = 8;
  localparam int SHIFT_W_DEF   = 4;
  localparam int MAX_SHIFT_DEF = 10;

  localparam int ACC_W  = DATA_W_DEF + FRAC_W_DEF;
  localparam int DIFF_W = ACC_W + 1;

  typedef logic [ACC_W-1:0] acc_t;

  // Requests beyond max_shift would only push the corner so low that the
  // guard bits could no longer represent the per-sample step; cap them.
  function automatic int clamp_shift(input int req, input int max_shift);
    return (req > max_shift) ? max_shift : req;
  endfunction

endpackage

// File: rtl/lp_filter_iir_if.sv
// lp_filter_iir_if: sample stream into and out of the IIR low-pass filter.
//   clear        : synchronous flush / re-prime request
//   in_valid     : in_data carries a new sample this cycle
//   in_data      : unsigned ADC sample
//   corner_shift : requested smoothing shift k (0 = pass-through)
//   out_valid    : single-cycle pulse, out_data carries a new filtered sample
//   out_data     : filtered, rounded and saturated sample
// Modports: master = sample source / consumer, slave = the filter.
interface lp_filter_iir_if #(
  parameter int DATA_W  = 12,
  parameter int SHIFT_W = 4
);

  logic               clear;
  logic               in_valid;
  logic [DATA_W-1:0]  in_data;
  logic [SHIFT_W-1:0] corner_shift;
  logic               out_valid;
  logic [DATA_W-1:0]  out_data;

  modport master (
    output clear, in_valid, in_data, corner_shift,
    input  out_valid, out_data
  );

  modport slave (
    input  clear, in_valid, in_data, corner_shift,
    output out_valid, out_data
  );

endinterface

// File: rtl/lp_filter_iir_stage.sv
// lp_iir_stage: one first-order exponential-moving-average section.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : drops the valid and primed state (accumulator left stale)
//   in_valid   : acc_in / k_in carry a sample this cycle
//   acc_in     : full-precision sample (integer + guard bits)
//   k_in       : clamped smoothing shift travelling with the sample
//   out_valid  : acc_out / k_out updated by this section last cycle
//   acc_out    : section accumulator, feeds the next section unrounded
//   k_out      : shift forwarded so every section uses the sample's own k
module lp_iir_stage
  import lp_filter_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int FRAC_W  = FRAC_W_DEF,
  parameter int SHIFT_W = SHIFT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic [DATA_W+FRAC_W-1:0] acc_in,
  input  logic [SHIFT_W-1:0]       k_in,
  output logic                     out_valid,
  output logic [DATA_W+FRAC_W-1:0] acc_out,
  output logic [SHIFT_W-1:0]       k_out
);

  localparam int ACC_BITS  = DATA_W + FRAC_W;
  localparam int DIFF_BITS = ACC_BITS + 1;

  logic                        primed;
  logic signed [DIFF_BITS-1:0] diff;
  logic signed [DIFF_BITS-1:0] step;
  logic [ACC_BITS-1:0]         acc_next;

  // acc + ((x - acc) >>> k). The result is a convex combination of x and acc,
  // so it always fits back into ACC_BITS and the truncating cast is exact.
  always_comb begin
    diff     = $signed({1'b0, acc_in}) - $signed({1'b0, acc_out});
    step     = diff >>> k_in;
    acc_next = ACC_BITS'($unsigned(step) + {1'b0, acc_out});
  end

  // The first sample after reset/clear loads the accumulator directly so the
  // output does not ramp up from zero. Idle cycles leave the state untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      primed    <= 1'b0;
      acc_out   <= '0;
      k_out     <= '0;
    end else if (clear) begin
      out_valid <= 1'b0;
      primed    <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        k_out <= k_in;
        if (primed) begin
          acc_out <= acc_next;
        end else begin
          acc_out <= acc_in;
          primed  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/lp_filter_iir.sv
// lp_filter_iir: cascaded first-order IIR low-pass filter for the ADC stream.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : lp_filter_iir_if slave (clear, in_valid, in_data,
//                corner_shift in; out_valid, out_data out)
// Latency is STAGES+1 cycles (one per section plus the output register),
// one sample per clock, no backpressure.
module lp_filter_iir
  import lp_filter_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int FRAC_W    = FRAC_W_DEF,
  parameter int STAGES    = 2,
  parameter int SHIFT_W   = SHIFT_W_DEF,
  parameter int MAX_SHIFT = MAX_SHIFT_DEF
) (
  input logic            clk,
  input logic            rst_n,
  lp_filter_iir_if.slave bus
);

  localparam int ACC_BITS = DATA_W + FRAC_W;
  localparam logic [ACC_BITS:0] HALF_LSB = (ACC_BITS+1)'(1) << (FRAC_W - 1);

  logic [STAGES:0]     valid_chain;
  logic [ACC_BITS-1:0] acc_chain [STAGES+1];
  logic [SHIFT_W-1:0]  k_chain   [STAGES+1];
  logic [DATA_W:0]     rounded;
  logic                out_valid_q;
  logic [DATA_W-1:0]   out_data_q;

  // Entry point of the chain: the sample gains FRAC_W zero guard bits and the
  // requested shift is clamped once, then carried alongside the sample.
  always_comb begin
    valid_chain[0] = bus.in_valid;
    acc_chain[0]   = {bus.in_data, {FRAC_W{1'b0}}};
    k_chain[0]     = SHIFT_W'(clamp_shift(32'(bus.corner_shift), MAX_SHIFT));
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    lp_iir_stage #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W),
      .SHIFT_W(SHIFT_W)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (bus.clear),
      .in_valid (valid_chain[i]),
      .acc_in   (acc_chain[i]),
      .k_in     (k_chain[i]),
      .out_valid(valid_chain[i+1]),
      .acc_out  (acc_chain[i+1]),
      .k_out    (k_chain[i+1])
    );
  end

  // Round half-up to the integer grid; the extra top bit flags the only
  // overflow case (full-scale plus one half LSB).
  always_comb begin
    rounded = (DATA_W+1)'(({1'b0, acc_chain[STAGES]} + HALF_LSB) >> FRAC_W);
  end

  // out_data holds between pulses; clear only kills the pending pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (bus.clear) begin
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= valid_chain[STAGES];
      if (valid_chain[STAGES]) begin
        out_data_q <= rounded[DATA_W] ? '1 : rounded[DATA_W-1:0];
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_lp_filter_iir.sv
// tb_lp_filter_iir: drives a 2-section and a 1-section lp_filter_iir with the
// same directed sample stream and checks both against a sample-level model.
module tb_lp_filter_iir;

  localparam int DATA_W    = 12;
  localparam int FRAC_W    = 8;
  localparam int SHIFT_W   = 4;
  localparam int MAX_SHIFT = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  lp_filter_iir_if #(.DATA_W(DATA_W), .SHIFT_W(SHIFT_W)) bus_s2 ();
  lp_filter_iir_if #(.DATA_W(DATA_W), .SHIFT_W(SHIFT_W)) bus_s1 ();

  lp_filter_iir #(
    .DATA_W(DATA_W), .FRAC_W(FRAC_W), .STAGES(2),
    .SHIFT_W(SHIFT_W), .MAX_SHIFT(MAX_SHIFT)
  ) dut_s2 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_s2)
  );

  lp_filter_iir #(
    .DATA_W(DATA_W), .FRAC_W(FRAC_W), .STAGES(1),
    .SHIFT_W(SHIFT_W), .MAX_SHIFT(MAX_SHIFT)
  ) dut_s1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_s1)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int edge_cnt = 0;

  // Model state, index 0 = two-section filter, index 1 = one-section filter.
  int     n_sect [2] = '{2, 1};
  longint m_acc  [2][4];
  bit     m_prim [2][4];
  int     m_last [2];
  int     due_s2 [$];
  int     val_s2 [$];
  int     due_s1 [$];
  int     val_s1 [$];
  int     cap_s2 [$];
  int     cap_s1 [$];
  int     pass_vals [16];

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Whole cascade evaluated at acceptance time: every section sees the same
  // clamped k, sections past the first take the previous full-precision value.
  function automatic int modelFilter(input int d, input int data, input int cs);
    int     k;
    longint x;
    longint r;
    k = (cs > MAX_SHIFT) ? MAX_SHIFT : cs;
    x = longint'(data) * (longint'(1) << FRAC_W);
    for (int s = 0; s < n_sect[d]; s++) begin
      if (!m_prim[d][s]) begin
        m_acc[d][s]  = x;
        m_prim[d][s] = 1'b1;
      end else begin
        m_acc[d][s] = m_acc[d][s] + ((x - m_acc[d][s]) >>> k);
      end
      x = m_acc[d][s];
    end
    r = (x + (longint'(1) << (FRAC_W - 1))) / (longint'(1) << FRAC_W);
    if (r > 4095) r = 4095;
    return int'(r);
  endfunction

  task automatic modelAccept(input int data, input int cs);
    due_s2.push_back(edge_cnt + 1 + n_sect[0]);
    val_s2.push_back(modelFilter(0, data, cs));
    due_s1.push_back(edge_cnt + 1 + n_sect[1]);
    val_s1.push_back(modelFilter(1, data, cs));
  endtask

  task automatic modelFlush();
    due_s2.delete(); val_s2.delete();
    due_s1.delete(); val_s1.delete();
    for (int d = 0; d < 2; d++)
      for (int s = 0; s < 4; s++) m_prim[d][s] = 1'b0;
  endtask

  function automatic int capAt(input int d, input int idx);
    if (d == 0) return (idx >= 0 && idx < cap_s2.size()) ? cap_s2[idx] : -1;
    return (idx >= 0 && idx < cap_s1.size()) ? cap_s1[idx] : -1;
  endfunction

  task automatic checkDut(input int d, input int v, input int data);
    int exp_v;
    exp_v = 0;
    if (d == 0) begin
      if (due_s2.size() > 0 && due_s2[0] == edge_cnt) begin
        exp_v = 1;
        void'(due_s2.pop_front());
        m_last[0] = val_s2.pop_front();
      end
    end else begin
      if (due_s1.size() > 0 && due_s1[0] == edge_cnt) begin
        exp_v = 1;
        void'(due_s1.pop_front());
        m_last[1] = val_s1.pop_front();
      end
    end
    checkOutput($sformatf("out_valid_s%0d@%0d", n_sect[d], edge_cnt), v, exp_v);
    checkOutput($sformatf("out_data_s%0d@%0d", n_sect[d], edge_cnt), data, m_last[d]);
    if (v == 1) begin
      if (d == 0) cap_s2.push_back(data);
      else cap_s1.push_back(data);
    end
  endtask

  // Single compare process, sampling away from the active edge.
  always @(negedge clk) begin
    checkDut(0, int'(bus_s2.out_valid), int'(bus_s2.out_data));
    checkDut(1, int'(bus_s1.out_valid), int'(bus_s1.out_data));
  end

  task automatic applyStimulus(input bit v, input int data, input int cs, input bit clr);
    bus_s2.in_valid = v;  bus_s2.in_data = 12'(data);
    bus_s2.corner_shift = 4'(cs);  bus_s2.clear = clr;
    bus_s1.in_valid = v;  bus_s1.in_data = 12'(data);
    bus_s1.corner_shift = 4'(cs);  bus_s1.clear = clr;
    @(posedge clk);
    if (clr) modelFlush();
    else if (v) modelAccept(data, cs);
    #1;
  endtask

  task automatic idle(input int n, input int cs);
    repeat (n) applyStimulus(1'b0, 0, cs, 1'b0);
  endtask

  task automatic clearCaps();
    cap_s2.delete();
    cap_s1.delete();
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus_s2.in_valid = 1'b0; bus_s2.in_data = '0; bus_s2.corner_shift = '0; bus_s2.clear = 1'b0;
    bus_s1.in_valid = 1'b0; bus_s1.in_data = '0; bus_s1.corner_shift = '0; bus_s1.clear = 1'b0;
    m_last = '{0, 0};
    modelFlush();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_out_valid_s2", int'(bus_s2.out_valid), 0);
    checkOutput("reset_out_data_s2", int'(bus_s2.out_data), 0);
    rst_n = 1'b1;
    idle(2, 0);

    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, 500, 2, 1'b0);
    applyStimulus(1'b1, 1500, 2, 1'b0);
    applyStimulus(1'b1, 2500, 2, 1'b0);
    applyStimulus(1'b1, 3500, 2, 1'b0);
    rst_n = 1'b0;
    modelFlush();
    m_last = '{0, 0};
    #1;
    checkOutput("async_rst_out_valid_s2", int'(bus_s2.out_valid), 0);
    checkOutput("async_rst_out_data_s2", int'(bus_s2.out_data), 0);
    checkOutput("async_rst_out_data_s1", int'(bus_s1.out_data), 0);
    idle(2, 2);
    rst_n = 1'b1;
    clearCaps();
    applyStimulus(1'b1, 1000, 2, 1'b0);
    idle(5, 2);
    checkOutput("prime_after_rst_count_s2", cap_s2.size(), 1);
    checkOutput("prime_after_rst_s2", capAt(0, 0), 1000);
    checkOutput("prime_after_rst_s1", capAt(1, 0), 1000);

    $display("[TB] step response k=1");
    applyStimulus(1'b0, 0, 1, 1'b1);
    clearCaps();
    applyStimulus(1'b1, 0, 1, 1'b0);
    applyStimulus(1'b1, 4095, 1, 1'b0);
    applyStimulus(1'b1, 4095, 1, 1'b0);
    idle(5, 1);
    checkOutput("step_0_s1", capAt(1, 0), 0);
    checkOutput("step_1_s1", capAt(1, 1), 2048);
    checkOutput("step_2_s1", capAt(1, 2), 3071);

    $display("[TB] pass-through k=0");
    applyStimulus(1'b0, 0, 0, 1'b1);
    clearCaps();
    for (int i = 0; i < 16; i++) begin
      pass_vals[i] = int'($urandom_range(0, 4095));
      applyStimulus(1'b1, pass_vals[i], 0, 1'b0);
    end
    idle(5, 0);
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("pass_s2_%0d", i), capAt(0, i), pass_vals[i]);
      checkOutput($sformatf("pass_s1_%0d", i), capAt(1, i), pass_vals[i]);
    end

    $display("[TB] shift clamp and full-scale input");
    applyStimulus(1'b0, 0, 15, 1'b1);
    for (int i = 0; i < 24; i++) applyStimulus(1'b1, (i * 1397) % 4096, 15, 1'b0);
    idle(4, 15);
    applyStimulus(1'b0, 0, 15, 1'b1);
    clearCaps();
    for (int i = 0; i < 5000; i++) applyStimulus(1'b1, 4095, 15, 1'b0);
    idle(5, 15);
    checkOutput("fullscale_count_s2", cap_s2.size(), 5000);
    checkOutput("fullscale_last_s2", capAt(0, cap_s2.size() - 1), 4095);

    $display("[TB] clear with samples in flight");
    clearCaps();
    applyStimulus(1'b1, 3000, 3, 1'b0);
    applyStimulus(1'b1, 100, 3, 1'b0);
    applyStimulus(1'b1, 777, 3, 1'b1);
    applyStimulus(1'b1, 200, 3, 1'b0);
    idle(6, 3);
    checkOutput("clear_count_s2", cap_s2.size(), 1);
    checkOutput("clear_reprime_s2", capAt(0, 0), 200);
    checkOutput("clear_count_s1", cap_s1.size(), 2);
    checkOutput("clear_reprime_s1", capAt(1, 1), 200);

    $display("[TB] gapped stream with k change");
    applyStimulus(1'b0, 0, 2, 1'b1);
    clearCaps();
    applyStimulus(1'b1, 1000, 2, 1'b0);
    idle(2, 4);
    applyStimulus(1'b1, 2000, 2, 1'b0);
    idle(2, 4);
    applyStimulus(1'b1, 2000, 4, 1'b0);
    idle(2, 4);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 300 + i * 611, (i < 3) ? 4 : 2, 1'b0);
      idle(2, (i < 3) ? 2 : 4);
    end
    idle(5, 2);
    checkOutput("gap_0_s2", capAt(0, 0), 1000);
    checkOutput("gap_1_s2", capAt(0, 1), 1063);
    checkOutput("gap_2_s2", capAt(0, 2), 1077);
    checkOutput("gap_0_s1", capAt(1, 0), 1000);
    checkOutput("gap_1_s1", capAt(1, 1), 1250);
    checkOutput("gap_2_s1", capAt(1, 2), 1297);
    checkOutput("gap_count_s2", cap_s2.size(), 9);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lp_filter_iir.md
Name: lp_filter_iir

Overview:
Parametrised cascaded first-order IIR low-pass filter (exponential moving average) for the ADC sample stream, placed between ADC capture and trigger/display logic. Corner frequency is runtime-selectable as a shift amount. The cascade depth is set at elaboration. It supports valid-qualified samples, first-sample priming and synchronous clear.

Parameters:
DATA_W, 12, unsigned sample width in/out
FRAC_W, 8, fractional guard bits held in each stage accumulator
STAGES, 2, number of cascaded first-order sections (1..4)
SHIFT_W, 4, width of corner_shift port
MAX_SHIFT, 10, largest effective shift; larger requests clamp to this

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous flush/re-prime request
in_valid  in  1  in_data holds a new sample this cycle
in_data  in  DATA_W  unsigned ADC sample
corner_shift  in  SHIFT_W  smoothing shift k; 0 = pass-through
out_valid  out  1  out_data holds a new filtered sample
out_data  out  DATA_W  filtered sample, rounded and saturated

Behaviour:
- Reset (rst_n low, async): all accumulators 0, all stage valids 0, all primed flags 0, out_valid 0, out_data 0.
- Effective shift k = min(corner_shift, MAX_SHIFT).
  - k is sampled when in_valid=1 and travels down the pipeline with that sample, so every stage uses the same k for it.
  - Changing corner_shift mid-stream affects only later samples.
- Stage input:
  - Stage 0 input x = {in_data, FRAC_W zeros}.
  - Stage i>0 input = full-precision accumulator of stage i-1; no rounding between stages.
- Stage update, on its input valid:
  - If not primed: acc <= x and primed <= 1. This avoids a ramp from 0.
  - Otherwise: acc <= acc + ((x - acc) >>> k).
  - The difference is signed, DATA_W+FRAC_W+1 bits, with an arithmetic shift.
  - k=0 gives acc = x exactly.
- Each stage is one register cycle. Latency from in_valid to out_valid is exactly STAGES+1 cycles: STAGES stages plus an output register.
- Throughput is one sample per clock. There is no backpressure.
- Output register:
  - out_data = (acc_last + 2^(FRAC_W-1)) >> FRAC_W, saturated to 2^DATA_W-1.
  - Only 4095 + 0.5 rounding can overflow.
  - out_valid is a single-cycle pulse per accepted sample.
  - out_data holds its value between pulses.
- clear (synchronous, highest priority):
  - Zeroes every stage valid and out_valid.
  - Drops primed flags; accumulators may hold stale values.
  - An in_valid in the same cycle as clear is discarded.
  - In-flight samples are lost.
  - The next accepted sample re-primes all stages.
- Idle cycles (in_valid=0) leave accumulators unchanged; the filter advances per sample, not per clock.
- Accumulators cannot overflow: acc always stays within [0, (2^DATA_W-1)·2^FRAC_W] because it is a convex combination.

Decomposition:
- Package lp_filter_pkg: ACC_W = DATA_W+FRAC_W, DIFF_W = ACC_W+1, a clamp-shift function, and the typedef acc_t.
- Sub-module lp_iir_stage: one section, with ports valid/acc_in/k_in and valid/acc_out/k_out, including the primed flag and clear.
- Top level: generate loop of STAGES lp_iir_stage instances, plus shift clamp and output round/saturate register.

Test Plan:
1. Reset mid-stream (STAGES=2): assert rst_n=0 during streaming -> out_valid=0 and out_data=0 immediately. First sample after release primes; in_data=1000 -> out_data=1000 three cycles later.
2. Step response (STAGES=1, k=1):
   - Samples 0, 4095, 4095 -> out_data 0, 2048, 3071.
   - out_valid pulses 2 cycles after each in_valid.
3. Pass-through (STAGES=2, k=0): random samples on consecutive cycles -> out_data equals in_data, delayed 3 cycles, every sample.
4. Clamp and saturation:
   - corner_shift=15 behaves identically to 10 (compare against a reference model).
   - Constant input 4095 for 5000 samples -> out_data=4095, never wraps.
5. clear: clear together with in_valid, with 2 samples in flight -> no out_valid for the dropped samples. Next sample 200 -> out_data=200 (re-primed).
6. Gapped stream and k change: in_valid every 3rd cycle; switch k 2->4 mid-stream -> outputs match the cycle-accurate reference model, and the k change applies only to samples accepted after it.
